axi_lite_irq_regbank: RTL

AXI_LITE_IRQ_REGBANK -- requirements
Module: axi_lite_irq_regbank

---
 rtl/axi_lite_irq_regbank_pkg.sv | 21 ++
 rtl/axi_lite_irq_regbank_irq_ctrl.sv | 42 ++++
 rtl/axi_lite_irq_regbank.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_irq_regbank_pkg.sv
// Shared definitions for the AXI-Lite interrupt/control register bank.
// This package holds the register indices, the response codes and the write-channel states.
package axi_lite_irq_regbank_pkg;

  localparam logic [31:0] IDX_ID     = 32'd0;
  localparam logic [31:0] IDX_STATUS = 32'd1;
  localparam logic [31:0] IDX_ENABLE = 32'd2;
  localparam logic [31:0] IDX_RAW    = 32'd3;
  localparam logic [31:0] IDX_CTRL0  = 32'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_irq_regbank_irq_ctrl.sv
// Interrupt block: detects rising edges on irq_src and keeps the sticky STATUS and the ENABLE registers.
// irq_out is the registered AND of STATUS and ENABLE.
module irq_ctrl #(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] status_clr,
  input  logic               enable_we,
  input  logic [NUM_IRQ-1:0] enable_wdata,
  input  logic [NUM_IRQ-1:0] enable_mask,
  output logic [NUM_IRQ-1:0] status,
  output logic [NUM_IRQ-1:0] enable,
  output logic [NUM_IRQ-1:0] irq_out
);

  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] rise;
  logic               armed;

  // armed stays low for the first cycle after reset, so a source that is already high is treated as a level and not as an edge
  assign rise = irq_src & ~irq_d & {NUM_IRQ{armed}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      irq_d   <= '0;
      status  <= '0;
      enable  <= '0;
      irq_out <= '0;
    end else begin
      armed   <= 1'b1;
      irq_d   <= irq_src;
      status  <= (status & ~status_clr) | rise;
      if (enable_we)
        enable <= (enable & ~enable_mask) | (enable_wdata & enable_mask);
      irq_out <= status & enable;
    end
  end

endmodule

// File: rtl/axi_lite_irq_regbank.sv
// AXI-Lite slave register bank. It holds the ID, STATUS, ENABLE and RAW interrupt registers,
// plus a set of read/write CTRL words and a set of read-only STAT words.
module axi_lite_irq_regbank
  import axi_lite_irq_regbank_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 12,
  parameter int          NUM_CTRL = 8,
  parameter int          NUM_IRQ  = 16,
  parameter logic [31:0] ID_VALUE = 32'h5A70_0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [NUM_IRQ-1:0]         irq_src,
  output logic [NUM_IRQ-1:0]         irq_out,
  output logic [NUM_CTRL*DATA_W-1:0] ctrl_o,
  input  logic [NUM_CTRL*DATA_W-1:0] stat_i
);

  localparam int          STRB_W    = DATA_W / 8;
  localparam int          ADDR_LSB  = $clog2(STRB_W);
  localparam logic [31:0] IDX_STAT0 = IDX_CTRL0 + 32'(NUM_CTRL);
  localparam logic [31:0] IDX_LIMIT = IDX_STAT0 + 32'(NUM_CTRL);

  wr_state_t                         state, state_nxt;
  logic [ADDR_W-1:0]                 aw_addr_q;
  logic [DATA_W-1:0]                 wdata_q;
  logic [STRB_W-1:0]                 wstrb_q;
  logic                              wr_fire;
  logic [ADDR_W-1:0]                 wr_addr;
  logic [DATA_W-1:0]                 wr_data;
  logic [STRB_W-1:0]                 wr_strb;
  logic [DATA_W-1:0]                 wr_mask;
  logic [31:0]                       wr_idx;
  logic [31:0]                       rd_idx;
  logic [DATA_W-1:0]                 rd_data;
  logic [1:0]                        rd_resp;
  logic [NUM_CTRL-1:0][DATA_W-1:0]   ctrl_q;
  logic [NUM_IRQ-1:0]                status;
  logic [NUM_IRQ-1:0]                enable;
  logic [NUM_IRQ-1:0]                status_clr;
  logic                              enable_we;
  logic                              unused_addr_lsbs;

  assign wr_idx           = 32'(wr_addr[ADDR_W-1:ADDR_LSB]);
  assign rd_idx           = 32'(s_axi_araddr[ADDR_W-1:ADDR_LSB]);
  assign unused_addr_lsbs = ^{wr_addr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  // The write takes effect on the cycle that completes the AW/W pair. A half that arrived earlier is taken from its holding register
  always_comb begin
    state_nxt     = state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_fire       = 1'b0;
    wr_addr       = aw_addr_q;
    wr_data       = wdata_q;
    wr_strb       = wstrb_q;
    case (state)
      IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        wr_addr       = s_axi_awaddr;
        wr_data       = s_axi_wdata;
        wr_strb       = s_axi_wstrb;
        if (s_axi_awvalid && s_axi_wvalid) begin
          wr_fire   = 1'b1;
          state_nxt = RESP;
        end else if (s_axi_awvalid) begin
          state_nxt = HAVE_AW;
        end else if (s_axi_wvalid) begin
          state_nxt = HAVE_W;
        end
      end
      HAVE_AW: begin
        s_axi_wready = 1'b1;
        wr_data      = s_axi_wdata;
        wr_strb      = s_axi_wstrb;
        if (s_axi_wvalid) begin
          wr_fire   = 1'b1;
          state_nxt = RESP;
        end
      end
      HAVE_W: begin
        s_axi_awready = 1'b1;
        wr_addr       = s_axi_awaddr;
        if (s_axi_awvalid) begin
          wr_fire   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++)
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      aw_addr_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_axi_bresp <= RESP_OKAY;
      ctrl_q      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && s_axi_awvalid)
        aw_addr_q <= s_axi_awaddr;
      if (state == IDLE && s_axi_wvalid) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_fire) begin
        s_axi_bresp <= (wr_idx < IDX_LIMIT) ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_CTRL; k++)
          if (wr_idx == IDX_CTRL0 + 32'(k))
            ctrl_q[k] <= (ctrl_q[k] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  assign ctrl_o     = ctrl_q;
  assign status_clr = (wr_fire && wr_idx == IDX_STATUS) ?
                      (wr_data[NUM_IRQ-1:0] & wr_mask[NUM_IRQ-1:0]) : '0;
  assign enable_we  = wr_fire && (wr_idx == IDX_ENABLE);

  irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq_ctrl (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .status_clr  (status_clr),
    .enable_we   (enable_we),
    .enable_wdata(wr_data[NUM_IRQ-1:0]),
    .enable_mask (wr_mask[NUM_IRQ-1:0]),
    .status      (status),
    .enable      (enable),
    .irq_out     (irq_out)
  );

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_idx == IDX_ID) begin
      rd_data[31:0] = ID_VALUE;
    end else if (rd_idx == IDX_STATUS) begin
      rd_data[NUM_IRQ-1:0] = status;
    end else if (rd_idx == IDX_ENABLE) begin
      rd_data[NUM_IRQ-1:0] = enable;
    end else if (rd_idx == IDX_RAW) begin
      rd_data[NUM_IRQ-1:0] = irq_src;
    end else if (rd_idx >= IDX_CTRL0 && rd_idx < IDX_LIMIT) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (rd_idx == IDX_CTRL0 + 32'(k))
          rd_data = ctrl_q[k];
        if (rd_idx == IDX_STAT0 + 32'(k))
          rd_data = stat_i[k*DATA_W +: DATA_W];
      end
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  assign s_axi_arready = !s_axi_rvalid;

  // Read data is captured at the AR handshake and held until the master takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule
